// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory with a fixed read latency.
// Instruction fetch and data memory share the port; one transaction is outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic done_c;
    logic free_c;
    logic pick_dm_c;
    logic grant_c;

    // Arbitration: DM has priority unless it won the previous grant.
    always_comb begin
        done_c    = (state_q == BUSY) && (cnt_q == '0);
        free_c    = ~rst & ((state_q == IDLE) | done_c);
        pick_dm_c = dm_req & (~if_req | (last_q != OWN_DM));
        grant_c   = free_c & (if_req | dm_req);
    end

    // Grant-cycle memory drive and completion-cycle return; all quiet during reset.
    always_comb begin
        if_gnt    = grant_c & ~pick_dm_c;
        dm_gnt    = grant_c & pick_dm_c;
        mem_en    = grant_c;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
        mem_wdata = dm_gnt ? dm_wdata : '0;
        if_valid  = ~rst & done_c & (owner_q == OWN_IF);
        dm_valid  = ~rst & done_c & (owner_q == OWN_DM);
        if_rdata  = if_valid ? mem_rdata : '0;
        dm_rdata  = dm_valid ? mem_rdata : '0;
        stall     = ~rst & ((if_req & ~if_gnt) | (dm_req & ~dm_gnt)
                            | ((state_q == BUSY) & ~done_c));
    end

    // Next state: a grant in the completion cycle restarts the counter back-to-back.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (grant_c) begin
            state_d = BUSY;
            owner_d = pick_dm_c ? OWN_DM : OWN_IF;
            last_d  = pick_dm_c ? OWN_DM : OWN_IF;
            cnt_d   = CNT_W'(MEM_LAT - 1);
        end else if (done_c) begin
            state_d = IDLE;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table plus random traffic against a
// transaction-level model that tracks the outstanding access by its completion time.
module tb_mem_port_arbiter;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic        dm_gnt, dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        stall;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // Model: one outstanding transaction, described by who owns it and when it completes.
    bit          m_busy = 1'b0;
    int          m_done = 0;
    bit          m_own_dm = 1'b0;
    bit          m_is_wr = 1'b0;
    bit          m_last_dm = 1'b0;
    logic [31:0] m_data = '0;
    int          ret_cyc = -1;
    logic [31:0] ret_data = '0;
    logic [31:0] mem [logic [31:0]];

    typedef struct {
        bit rst, ifr, dmr, dwe;
        bit ig, dg, iv, dv, st;
    } vec_t;
    vec_t tbl [30];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs, compare every output with the model, then advance the model.
    task automatic cycle(input logic r, input logic ifr, input logic [31:0] ia,
                         input logic dmr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        bit done, free, gany, wdm, e_ig, e_dg, e_st;
        logic [31:0] e_addr;
        @(negedge clk);
        rst = r; if_req = ifr; if_addr = ia;
        dm_req = dmr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
        mem_rdata = (cyc == ret_cyc) ? ret_data : 32'($urandom);
        done = !r && m_busy && (cyc == m_done);
        free = !m_busy || (cyc == m_done);
        gany = !r && free && (ifr || dmr);
        wdm  = dmr && (!ifr || !m_last_dm);
        e_ig = gany && !wdm;
        e_dg = gany && wdm;
        e_st = !r && ((ifr && !e_ig) || (dmr && !e_dg) || (m_busy && !done));
        e_addr = e_ig ? ia : (e_dg ? da : 32'h0);
        #2;
        chk("if_gnt",    32'(if_gnt),    32'(e_ig));
        chk("dm_gnt",    32'(dm_gnt),    32'(e_dg));
        chk("mem_en",    32'(mem_en),    32'(gany));
        chk("mem_we",    32'(mem_we),    32'(e_dg && dwe));
        chk("mem_addr",  mem_addr,       e_addr);
        chk("mem_wdata", mem_wdata,      e_dg ? dwd : 32'h0);
        chk("if_valid",  32'(if_valid),  32'(done && !m_own_dm));
        chk("if_rdata",  if_rdata,       (done && !m_own_dm) ? m_data : 32'h0);
        chk("dm_valid",  32'(dm_valid),  32'(done && m_own_dm));
        if (!(done && m_own_dm && m_is_wr))
            chk("dm_rdata", dm_rdata, (done && m_own_dm) ? m_data : 32'h0);
        chk("stall",     32'(stall),     32'(e_st));
        if (r) begin
            m_busy = 1'b0;
            m_last_dm = 1'b0;
        end else if (gany) begin
            m_busy    = 1'b1;
            m_done    = cyc + int'(LAT);
            m_own_dm  = wdm;
            m_last_dm = wdm;
            m_is_wr   = wdm && dwe;
            if (wdm && dwe) begin
                mem[da] = dwd;
                m_data  = 32'h0;
                ret_data = 32'($urandom);
            end else begin
                m_data   = rd_mem(wdm ? da : ia);
                ret_data = m_data;
            end
            ret_cyc = cyc + int'(LAT);
        end else if (done) begin
            m_busy = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        //            rst ifr dmr dwe   ig dg iv dv st
        tbl[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0,  0, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 0,  1, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 1,  0, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 0,  0, 0, 0, 1, 0};
        tbl[13] = '{1, 1, 1, 0,  0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 1, 0,  0, 1, 0, 0, 1};
        tbl[15] = '{0, 1, 1, 0,  0, 0, 0, 0, 1};
        tbl[16] = '{0, 1, 1, 0,  1, 0, 0, 1, 1};
        tbl[17] = '{0, 1, 1, 0,  0, 0, 0, 0, 1};
        tbl[18] = '{0, 1, 1, 0,  0, 1, 1, 0, 1};
        tbl[19] = '{0, 1, 1, 0,  0, 0, 0, 0, 1};
        tbl[20] = '{0, 1, 1, 0,  1, 0, 0, 1, 1};
        tbl[21] = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[22] = '{0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[23] = '{0, 0, 1, 0,  0, 1, 0, 0, 0};
        tbl[24] = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[25] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[26] = '{0, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[27] = '{0, 0, 1, 0,  0, 0, 0, 0, 1};
        tbl[28] = '{0, 0, 0, 0,  0, 0, 1, 0, 0};
        tbl[29] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        mem[32'h10] = 32'hDEAD_BEEF;

        for (int i = 0; i < 30; i++) begin
            cycle(tbl[i].rst, tbl[i].ifr, 32'h10, tbl[i].dmr, tbl[i].dwe, 32'h40, 32'h55);
            chk($sformatf("v%0d_if_gnt", i),   32'(if_gnt),   32'(tbl[i].ig));
            chk($sformatf("v%0d_dm_gnt", i),   32'(dm_gnt),   32'(tbl[i].dg));
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].iv));
            chk($sformatf("v%0d_dm_valid", i), 32'(dm_valid), 32'(tbl[i].dv));
            chk($sformatf("v%0d_stall", i),    32'(stall),    32'(tbl[i].st));
            if (i == 3)
                chk("v3_if_rdata_deadbeef", if_rdata, 32'hDEAD_BEEF);
            if (i == 10) begin
                chk("v10_mem_we", 32'(mem_we), 32'h1);
                chk("v10_mem_wdata", mem_wdata, 32'h55);
                chk("v10_mem_addr", mem_addr, 32'h40);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 9) < 6), 32'($urandom) & 32'hFC,
                  1'($urandom_range(0, 9) < 6), 1'($urandom),
                  32'($urandom) & 32'hFC, 32'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning cycles from issue to response (legal range 1..4).
REQ-002 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req  input  1  instruction-fetch read request, held until granted.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_valid  output  1  fetch data valid, 1-cycle pulse.
REQ-008 SHALL have port if_rdata  output  32  fetch data, meaningful only when if_valid=1.
REQ-009 SHALL have port dm_req  input  1  data-memory request, held until granted.
REQ-010 SHALL have port dm_we  input  1  1=write, 0=read.
REQ-011 SHALL have port dm_addr  input  32  data address.
REQ-012 SHALL have port dm_wdata  input  32  write data.
REQ-013 SHALL have port dm_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port dm_valid  output  1  data transaction complete (read data or write ack), 1-cycle pulse.
REQ-015 SHALL have port dm_rdata  output  32  read data, meaningful only when dm_valid=1 and the transaction was a read.
REQ-016 SHALL have port mem_en  output  1  single-port memory issue strobe.
REQ-017 SHALL have port mem_we  output  1  memory write enable, qualified by mem_en.
REQ-018 SHALL have port mem_addr  output  32  memory address.
REQ-019 SHALL have port mem_wdata  output  32  memory write data.
REQ-020 SHALL have port mem_rdata  input  32  memory read data, valid MEM_LAT cycles after issue.
REQ-021 SHALL have port stall  output  1  freeze request to the pipeline hazard logic.

Function
REQ-022 SHALL implement FSM {IDLE, BUSY}, with owner register {IF, DM}, latency counter (3 bits), and last_winner bit.
REQ-023 SHALL allow at most one outstanding transaction at any time.
REQ-024 SHALL grant (gnt=1, mem_en=1, combinational) in any cycle where state=IDLE, or state=BUSY with the counter completing, and at least one req=1.
REQ-025 SHALL resolve arbitration as follows when both req=1: DM wins unless last_winner=DM, in which case IF wins; a single requester always wins.
REQ-026 SHALL update last_winner to the granted requester on every grant.
REQ-027 SHALL drive mem_addr/mem_we/mem_wdata from the winner in the grant cycle: mem_we=dm_we for DM, mem_we=0 for IF. Outside the grant cycle these outputs are 0.
REQ-028 SHALL, on a grant, enter BUSY, latch owner, and load the counter with MEM_LAT-1.
REQ-029 SHALL decrement the counter each BUSY cycle; the cycle with counter=0 is the completion cycle.
REQ-030 SHALL, in the completion cycle, pulse the owner's valid and pass mem_rdata to the owner's rdata; latency is exactly MEM_LAT cycles from grant to valid.
REQ-031 SHALL return to IDLE after the completion cycle if no grant occurs in that same cycle.
REQ-032 SHALL, on a grant issued in the completion cycle, let the new transaction start back-to-back; throughput is one transaction per MEM_LAT cycles.
REQ-033 SHALL treat a req deasserted before grant as withdrawn, with no transaction issued.
REQ-034 SHALL assert stall = (if_req & ~if_gnt) | (dm_req & ~dm_gnt) | (state=BUSY & ~completion cycle).
REQ-035 SHALL hold inactive rdata outputs at 0.

Reset
REQ-036 SHALL, while rst=1 at a clock edge, set state=IDLE, owner=IF, counter=0, last_winner=IF; all gnt/valid/mem_* outputs and stall are 0 during rst.
REQ-037 SHALL abandon an outstanding transaction on a reset mid-operation: no valid pulse follows, and memory data returning afterwards is ignored.
REQ-038 SHALL accept the first grant in the first cycle with rst=0.

Verification (MEM_LAT=2)
REQ-039 SHALL cover: IF-only read at cycle 0, addr 0x10, mem returns 0xDEADBEEF -> if_gnt at cycle 0, if_valid plus data at cycle 2, stall=1 in cycle 1 only.
REQ-040 SHALL cover: if_req and dm_req both asserted continuously from reset -> grants alternate DM, IF, DM, IF every 2 cycles, with no starvation.
REQ-041 SHALL cover: DM write addr 0x40, data 0x55 -> mem_en=1, mem_we=1, mem_wdata=0x55 in the grant cycle; dm_valid 2 cycles later; if_valid never pulses.
REQ-042 SHALL cover: back-to-back IF requests -> second if_gnt occurs in the same cycle as the first if_valid.
REQ-043 SHALL cover: rst asserted one cycle after a DM read grant -> no dm_valid pulse, IDLE state, all outputs 0.
REQ-044 SHALL cover: dm_req dropped while an IF transaction is in progress -> no DM issue, and stall clears at IF completion.
